// File: rtl/whackamole_pkg.sv
// -----------------------------------------------------------------------------
// whackamole_pkg
//
// Shared definitions for the whack-a-mole game blocks.
//   mole_state_t  : state encoding of the mole generator
//   CNT_W         : width of the dwell/gap counter and the period register
//   LFSR_SEED     : power-on value of the 16-bit position LFSR
//   LFSR_TAPS     : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   next_mole_pos : turns an LFSR candidate into a position that never equals
//                   the currently displayed one
// -----------------------------------------------------------------------------
package whackamole_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2,
      ST_OVER = 2'd3
   } mole_state_t;

   localparam int unsigned CNT_W = 28;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // A repeat of the current hole is bumped to the next hole (wrapping 7 -> 0),
   // so two consecutive moles are never in the same place.
   function automatic logic [2:0] next_mole_pos(input logic [2:0] cand,
                                                input logic [2:0] cur);
      return (cand == cur) ? cand + 3'd1 : cand;
   endfunction

endpackage

// File: rtl/mole_generator_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
//
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11. Shifts left every
// clock, feedback enters at bit 0. Never stalls, so the sequence position is a
// pure function of the number of clocks since reset.
//
// Ports
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, loads LFSR_SEED
//   q   : current LFSR contents
// -----------------------------------------------------------------------------
module lfsr16
   import whackamole_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic fb;

   assign fb = ^(q & LFSR_TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[14:0], fb};
      end
   end

endmodule

// File: rtl/mole_generator.sv
// -----------------------------------------------------------------------------
// mole_generator
//
// Decides where the mole appears and for how long. A mole is shown for
// `period` cycles; if it is not hit it jumps to a new hole. A hit blanks the
// display for GAP_CYCLES, shortens the dwell by PERIOD_STEP (never below
// MIN_PERIOD) and then shows a new mole. Game over freezes the display until
// a restart.
//
// Parameters
//   MOLE_PERIOD : initial dwell in clk cycles
//   PERIOD_STEP : dwell reduction per hit
//   MIN_PERIOD  : dwell floor
//   GAP_CYCLES  : blank time after a hit
//
// Ports
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   i_restart_game : start / restart request (sampled synchronously)
//   i_game_over    : level, game timer expired
//   guess_correct  : one-cycle hit pulse, only honoured while a mole is shown
//   mole_pos       : current mole hole 0..7
//   mole_change    : one-cycle pulse, coincident with a new mole_pos value
//   mole_active    : high while a mole is displayed
//
// Event priority: restart > game over > hit > dwell/gap timeout.
// All outputs are registered; an event seen on cycle N is visible on N+1.
// -----------------------------------------------------------------------------
module mole_generator
   import whackamole_pkg::*;
#(
   parameter int unsigned MOLE_PERIOD = 100000000,
   parameter int unsigned PERIOD_STEP = 5000000,
   parameter int unsigned MIN_PERIOD  = 30000000,
   parameter int unsigned GAP_CYCLES  = 25000000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_restart_game,
   input  logic       i_game_over,
   input  logic       guess_correct,
   output logic [2:0] mole_pos,
   output logic       mole_change,
   output logic       mole_active
);

   localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(MOLE_PERIOD);
   localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(PERIOD_STEP);
   localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   mole_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] period_last;
   logic [15:0]      lfsr_q;
   logic [2:0]       pos_next;
   logic             lfsr_unused;

   // Dwell shrink after a hit: subtraction saturates at zero, then the result
   // is clamped up to the floor.
   function automatic logic [CNT_W-1:0] shrink_period(input logic [CNT_W-1:0] p);
      logic [CNT_W-1:0] d;
      d = (p >= STEP_C) ? p - STEP_C : '0;
      return (d < MIN_C) ? MIN_C : d;
   endfunction

   lfsr16 u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   // Only the low three bits choose a hole; the rest just feed the shift chain.
   assign lfsr_unused = ^lfsr_q[15:3];

   assign pos_next    = next_mole_pos(lfsr_q[2:0], mole_pos);
   assign period_last = period - CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         period      <= PERIOD_INIT;
         mole_pos    <= 3'd0;
         mole_change <= 1'b0;
         mole_active <= 1'b0;
      end else begin
         mole_change <= 1'b0;

         if (i_restart_game) begin
            // Restart wins over everything, from any state.
            state       <= ST_SHOW;
            period      <= PERIOD_INIT;
            cnt         <= '0;
            mole_pos    <= pos_next;
            mole_change <= 1'b1;
            mole_active <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  mole_active <= 1'b0;
               end

               ST_SHOW: begin
                  if (i_game_over) begin
                     state       <= ST_OVER;
                     cnt         <= '0;
                     mole_active <= 1'b0;
                  end else if (guess_correct) begin
                     // A hit on the timeout cycle still counts as a hit.
                     state       <= ST_GAP;
                     cnt         <= '0;
                     period      <= shrink_period(period);
                     mole_active <= 1'b0;
                  end else if (cnt == period_last) begin
                     cnt         <= '0;
                     mole_pos    <= pos_next;
                     mole_change <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               ST_GAP: begin
                  if (i_game_over) begin
                     state       <= ST_OVER;
                     cnt         <= '0;
                     mole_active <= 1'b0;
                  end else if (cnt == GAP_LAST) begin
                     state       <= ST_SHOW;
                     cnt         <= '0;
                     mole_pos    <= pos_next;
                     mole_change <= 1'b1;
                     mole_active <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               ST_OVER: begin
                  // Frozen: position held, nothing displayed, until restart.
                  mole_active <= 1'b0;
               end

               default: begin
                  state       <= ST_IDLE;
                  cnt         <= '0;
                  mole_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/mole_generator.md
MOLE_GENERATOR -- requirements
Module: mole_generator

Interface
REQ-001 SHALL have parameter MOLE_PERIOD, default 100000000, initial mole dwell time in clk cycles (1 s).
REQ-002 SHALL have parameter PERIOD_STEP, default 5000000, dwell reduction per correct hit.
REQ-003 SHALL have parameter MIN_PERIOD, default 30000000, dwell floor.
REQ-004 SHALL have parameter GAP_CYCLES, default 25000000, blank time after a hit.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port i_restart_game, input, 1, synchronous start/restart request.
REQ-008 SHALL have port i_game_over, input, 1, level; game timer expired.
REQ-009 SHALL have port guess_correct, input, 1, one-cycle hit pulse from score evaluation.
REQ-010 SHALL have port mole_pos, output, 3, current mole hole (0-7).
REQ-011 SHALL have port mole_change, output, 1, one-cycle pulse on the cycle mole_pos takes a new value.
REQ-012 SHALL have port mole_active, output, 1, high while a mole is displayed.

Function
REQ-013 SHALL implement states IDLE, SHOW, GAP and OVER.
REQ-014 SHALL keep a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 16'hACE1, advancing every cycle in all states.
REQ-015 SHALL form candidate = lfsr[2:0], and use (candidate+1) mod 8 when candidate equals the current mole_pos, so consecutive positions always differ.
REQ-016 SHALL use a 28-bit dwell counter, cleared on every state entry and on every mole_change.
REQ-017 SHALL hold a period register, loaded with MOLE_PERIOD on restart.
REQ-018 In IDLE: mole_active=0; on i_restart_game, SHALL go to SHOW, load a new position and pulse mole_change.
REQ-019 In SHOW: mole_active=1; on guess_correct, SHALL go to GAP and set period to max(period-PERIOD_STEP, MIN_PERIOD) with saturating subtraction.
REQ-020 In SHOW with no hit, when counter==period-1, SHALL load a new position, pulse mole_change, clear the counter and remain in SHOW.
REQ-021 SHALL give guess_correct priority over timeout when both occur in the same SHOW cycle.
REQ-022 SHALL ignore guess_correct outside SHOW.
REQ-023 In GAP: mole_active=0; when counter==GAP_CYCLES-1, SHALL go to SHOW, load a new position and pulse mole_change.
REQ-024 SHALL enter OVER from SHOW or GAP on i_game_over=1; in OVER: mole_active=0, mole_pos held, no mole_change.
REQ-025 From any state, i_restart_game SHALL reload period, go to SHOW with a new position and pulse mole_change.
REQ-026 SHALL apply priority i_restart_game > i_game_over > guess_correct > timeout.
REQ-027 SHALL present a new mole_pos on the same cycle mole_change is high; latency from the triggering event is 1 clk.

Reset
REQ-028 On rst: state=IDLE, mole_pos=0, mole_change=0, mole_active=0, counter=0, period=MOLE_PERIOD, lfsr=16'hACE1.
REQ-029 rst SHALL take effect mid-dwell or mid-gap with no completion pulse.

Structure
REQ-030 The state encoding, LFSR seed and tap constants SHALL live in the shared whackamole package.
REQ-031 The LFSR SHALL be a sub-module named lfsr16 (ports clk, rst, q[15:0]); all other logic stays flat.

Verification
(Bench parameters: MOLE_PERIOD=20, PERIOD_STEP=4, MIN_PERIOD=8, GAP_CYCLES=3.)
REQ-032 rst, then i_restart_game pulse -> next cycle mole_change=1, mole_active=1; with no hit, mole_change repeats every 20 cycles and mole_pos never repeats consecutively.
REQ-033 guess_correct in SHOW -> mole_active=0 for 3 cycles, then mole_change=1; the next dwell is 16 cycles.
REQ-034 5 consecutive hits -> dwell sequence 16, 12, 8, 8, 8 (saturation at MIN_PERIOD).
REQ-035 guess_correct on the timeout cycle -> enter GAP and no timeout mole_change; i_game_over together with guess_correct -> OVER with period unchanged.
REQ-036 i_game_over=1 -> mole_active=0, no mole_change for 100 cycles; i_restart_game alone -> SHOW with period 20.
REQ-037 rst asserted asynchronously mid-GAP -> all outputs 0 immediately and state IDLE.
